// File: rtl/uart_rx_os_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// The receiver's optional 8E1 framing is selected with the macro UART_RX_PARITY_EN.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Clocks per oversample tick; integer truncation is intentional.
  function automatic int uart_div(input int clock, input int baud, input int oversample);
    return clock / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider: counts 0..DIV-1 while enabled and pulses tick on DIV-1.
// The count is frozen while enable is low, and tick is suppressed so nothing advances.
module uart_os_tick #(
  parameter int DIV = 325
) (
  input  logic baud_clk_in,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap after DIV-1, hold while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge baud_clk_in or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver, 8N1 by default; 8E1 with a parity_err output when
// UART_RX_PARITY_EN is defined. Bytes leave through a valid/ready handshake; a byte
// completing while the previous one is still unconsumed is dropped and flagged.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLOCK      = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 baud_clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int DIV = uart_div(CLOCK, BAUD, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  logic                 tick;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  uart_state_e          state_q;
  logic [OSW-1:0]       os_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 armed_q;
  logic                 par_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_q;
  logic                 parity_err_q;
`endif

  uart_os_tick #(.DIV(DIV)) u_tick (
    .baud_clk_in (baud_clk_in),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick)
  );

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge baud_clk_in or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_bad = (^shift_q) ^ par_q;
`else
  assign par_bad = 1'b0;
`endif

  // Frame FSM plus output handshake, all registered.
  always_ff @(posedge baud_clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      os_cnt_q     <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      armed_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (!enable) begin
        state_q <= IDLE;
      end else if (tick) begin
        case (state_q)
          IDLE: begin
            // After a framing error the line must be seen high before a new start is accepted.
            if (rx_s_q) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              os_cnt_q <= '0;
              state_q  <= START;
            end
          end
          START: begin
            if (os_cnt_q == OS_HALF) begin
              if (!rx_s_q) begin
                os_cnt_q  <= '0;
                bit_idx_q <= '0;
                state_q   <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              os_cnt_q <= os_cnt_q + OSW'(1);
            end
          end
          DATA: begin
            os_cnt_q <= os_cnt_q + OSW'(1);
            if (os_cnt_q == OS_LAST) begin
              shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            os_cnt_q <= os_cnt_q + OSW'(1);
            if (os_cnt_q == OS_LAST) begin
              par_q   <= rx_s_q;
              state_q <= STOP;
            end
          end
`endif
          STOP: begin
            os_cnt_q <= os_cnt_q + OSW'(1);
            if (os_cnt_q == OS_LAST) begin
              state_q <= IDLE;
              if (!rx_s_q) begin
                frame_err_q <= 1'b1;
                armed_q     <= 1'b0;
              end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b1;
`endif
              end else if (rx_valid_q && !rx_ready) begin
                overrun_q <= 1'b1;
              end else begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frames are serialised from a bit list, the expected outcome
// of each frame is queued by a frame-level model, and a monitor checks every
// delivered byte and every error pulse against it.
module tb_uart_rx_os;

  localparam int CLOCK = 500000;
  localparam int BAUD  = 9600;
  localparam int OS    = 16;
  localparam int DIV   = CLOCK / (BAUD * OS);
  localparam int BIT   = DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAST_SAMPLE = ((2 * FRAME_BITS - 1) * BIT) / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_os #(.CLOCK(CLOCK), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .baud_clk_in (clk),
    .reset       (reset),
    .enable      (enable),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int  exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  int  got_ferr = 0, got_ovr = 0, got_perr = 0;
  bit  pending = 0;
  int  t_start = 0;
  int  last_rise = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and tallies error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) got_ferr++;
      if (overrun) got_ovr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) got_perr++;
`endif
      if (rx_valid && !prev_valid) last_rise = cyc;
      if (rx_valid && prev_valid) check("rx_data stable while valid", rx_data, prev_data);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected byte: got 0x%0h expected none", rx_data);
        end else begin
          check("delivered byte", rx_data, exp_q.pop_front());
        end
      end
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Frame-level model: what the receiver must report for one complete frame.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    if (!stop_ok) exp_ferr++;
    else if (!par_ok) exp_perr++;
    else if (pending) exp_ovr++;
    else begin
      exp_q.push_back(b);
      if (!rx_ready) pending = 1;
    end
  endtask

  task automatic idle(input int clocks);
    rx = 1'b1;
    repeat (clocks) @(posedge clk);
    #1;
  endtask

  // abort: 0 none, 1 reset pulse at data bit 4, 2 enable drop at data bit 4.
  task automatic send(input logic [7:0] b, input bit stop_v, input bit bad_par, input int abort);
    bit frame[$];
    frame.push_back(1'b0);
    for (int i = 0; i < 8; i++) frame.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
    frame.push_back((^b) ^ bad_par);
`endif
    frame.push_back(stop_v);
    if (abort == 0) model_frame(b, stop_v, !bad_par);
    for (int i = 0; i < frame.size(); i++) begin
      rx = frame[i];
      if (i == 0) t_start = cyc;
      if (i == 5 && abort != 0) begin
        repeat (2) @(posedge clk);
        #1;
        if (abort == 1) begin
          reset = 1'b1;
          #1;
          check("rx_valid during reset", rx_valid, 0);
          check("rx_data during reset", rx_data, 0);
        end else begin
          enable = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        repeat (BIT - 6) @(posedge clk);
        #1;
      end else begin
        repeat (BIT) @(posedge clk);
        #1;
      end
    end
    rx = 1'b1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " frame_err pulses"}, got_ferr, exp_ferr);
    check({tag, " overrun pulses"}, got_ovr, exp_ovr);
    check({tag, " parity_err pulses"}, got_perr, exp_perr);
    check({tag, " undelivered bytes"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_data", rx_data, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    reset = 1'b0;
    idle(2 * BIT);

    // Single byte with ready held high, plus first-byte latency.
    send(8'hA5, 1'b1, 1'b0, 0);
    idle(BIT);
    check("A5 latency in window", int'((last_rise - t_start) >= LAST_SAMPLE + 1 &&
                                      (last_rise - t_start) <= LAST_SAMPLE + 7), 1);
    check_counts("A5");

    // Overrun: hold the first byte, the second is lost.
    rx_ready = 1'b0;
    send(8'h3C, 1'b1, 1'b0, 0);
    idle(BIT);
    send(8'h81, 1'b1, 1'b0, 0);
    idle(BIT);
    check("held rx_valid", rx_valid, 1);
    check("held rx_data", rx_data, 8'h3C);
    check("overrun count", got_ovr, exp_ovr);
    rx_ready = 1'b1;
    pending  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rx_valid cleared after consume", rx_valid, 0);
    check_counts("overrun");

    // Framing error then recovery.
    send(8'h55, 1'b0, 1'b0, 0);
    idle(2 * BIT);
    check("rx_valid after frame_err", rx_valid, 0);
    send(8'h12, 1'b1, 1'b0, 0);
    idle(BIT);
    check_counts("frame_err");

    // Short glitch on an idle line.
    rx = 1'b0;
    repeat (BIT / 4) @(posedge clk);
    #1;
    idle(2 * BIT);
    check_counts("glitch");

    // Reset mid-frame, then a clean byte.
    send(8'hF0, 1'b1, 1'b0, 1);
    idle(BIT);
    send(8'h0F, 1'b1, 1'b0, 0);
    idle(BIT);
    check_counts("reset abort");

    // Enable drop mid-frame keeps the last byte and discards the partial one.
    send(8'hF0, 1'b1, 1'b0, 2);
    check("rx_data kept over enable drop", rx_data, 8'h0F);
    idle(BIT);
    send(8'h0F, 1'b1, 1'b0, 0);
    idle(BIT);
    check_counts("enable abort");

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 0);
    idle(BIT);
    send(8'h07, 1'b1, 1'b1, 0);
    idle(BIT);
    check_counts("parity");
`endif

    // Randomized frames with occasional stop/parity errors and ready stalls.
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      bit stop_v, bad_par;
      b = 8'($urandom);
      stop_v = ($urandom_range(0, 5) != 0);
      bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_par = ($urandom_range(0, 5) == 0);
`endif
      rx_ready = ($urandom_range(0, 3) != 0);
      send(b, stop_v, bad_par, 0);
      idle(BIT + $urandom_range(0, BIT));
      if (!rx_ready) begin
        rx_ready = 1'b1;
        pending  = 0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    idle(BIT);
    check_counts("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receiver for the serial link: the receiving end of the 8N1 stream paced by the team's baud divider.
- Oversamples the asynchronous rx line at OVERSAMPLE × BAUD, using an internal tick divider.
- Locates the start bit, samples each bit at mid-period and delivers bytes through a valid/ready handshake.
- Sits between the board RX pin and the ADC command/response logic.

Parameters:
- CLOCK, 50000000, input clock frequency in Hz.
- BAUD, 9600, serial bit rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; must be a power of two, 8 or more.
- Derived constant DIV = CLOCK/(BAUD*OVERSAMPLE), integer truncation; default 325, giving 5200 clocks per bit.

Ports:
- baud_clk_in  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  receiver enable; low aborts any frame and holds the tick divider.
- rx  in  1  asynchronous serial line, idle high.
- rx_data  out  8  received byte; LSB was first on the line.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready at a rising edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a byte was dropped because the previous byte was not consumed.

Behaviour:
- Reset values:
  - rx_data = 8'h00; rx_valid, frame_err, overrun = 0.
  - FSM = IDLE; tick counter = 0; oversample count = 0.
  - Both stages of the rx synchronizer = 1.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Tick generator:
  - Counter runs 0..DIV-1 while enable is high.
  - tick is a one-cycle pulse when the counter equals DIV-1, then the counter wraps to 0.
  - enable low holds the counter at its current value.
- FSM states: IDLE, START, DATA, STOP. The FSM advances only on tick.
  - IDLE: on a tick with rx_s = 0, clear os_cnt and go to START.
  - START: when os_cnt reaches OVERSAMPLE/2-1 (mid start bit), check rx_s.
    - rx_s = 0: clear os_cnt and bit_idx, go to DATA.
    - rx_s = 1: glitch; return to IDLE with no output or error.
  - DATA: every OVERSAMPLE ticks, shift rx_s into a shift register, LSB first, and increment bit_idx. After bit 7 is sampled, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - 1: complete the byte; go to IDLE.
    - 0: assert frame_err for one cycle, discard the byte, go to IDLE. The receiver re-arms only after a high tick sample, so a break condition yields no repeated errors.
- Latency: rx_valid rises 1 clock after the stop-bit sample tick, about 9.5 bit periods after the start-bit falling edge.
- Handshake:
  - rx_valid stays high until a rising edge with rx_ready = 1, then clears.
  - rx_data is stable while rx_valid is high.
- Byte completion, with P = rx_valid && !rx_ready:
  - P true: rx_data is unchanged, rx_valid stays 1, overrun pulses for one cycle, and the new byte is lost.
  - P false (including a consume in the same cycle): the new byte loads, rx_valid = 1, no overrun.
- enable deasserted mid-frame: FSM goes to IDLE on the next clock and the partial byte is discarded. rx_data and rx_valid keep their state and handshake still works.
- Asynchronous reset mid-frame: every register returns to its reset value immediately.
- Width rules:
  - Tick counter width = $clog2(DIV).
  - os_cnt width = $clog2(OVERSAMPLE); it wraps naturally.
  - bit_idx is 3 bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1.
  - A PARITY state is inserted between DATA and STOP and samples one bit period.
  - A parity_err output port (1 bit, one-cycle pulse) is added.
  - On mismatch with even parity over the data bits, parity_err pulses at the stop sample and the byte is discarded. frame_err has priority if both apply.
- Undefined: 8N1 as above, and no parity_err port.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS = 8;
  - a function computing DIV from CLOCK, BAUD and OVERSAMPLE.
- Sub-module uart_os_tick: tick divider with enable and asynchronous reset, parameterised by DIV. Instantiated once.

Test Plan:
- Send 0xA5 as 8N1 at 5200 clocks/bit with rx_ready held 1 -> one-cycle rx_valid pulse with rx_data = 0xA5 about 49400 clocks after the start edge; no errors.
- Send 0x3C with rx_ready = 0, then 0x81 -> rx_data stays 0x3C with rx_valid high; overrun pulses once at the end of 0x81. Raise rx_ready -> rx_valid clears.
- Send 0x55 with the stop bit forced to 0 -> one frame_err pulse, rx_valid stays 0. Release the line high, then send 0x12 -> received correctly.
- Drive a 1000-clock low glitch on an idle line -> FSM returns to IDLE; no rx_valid or frame_err.
- Assert reset at bit 4 of 0xF0, release it, then send 0x0F -> only 0x0F is delivered. Repeat with enable dropped at bit 4 -> same result.
- With UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 -> byte delivered. Send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid.
